// File: rtl/rf_writeback_arbiter_if.sv
// Result/handshake bundle between the register-file writeback arbiter and its producers.
// Bypass taps exist only when RF_WB_BYPASS_EN is defined.
interface rf_writeback_arbiter_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic [4:0]    wb_reg;
  logic          wb_mem_to_reg;
  logic [31:0]   wb_alu_result;
  logic [31:0]   wb_mem_data;
  logic          ll_valid;
  logic          ll_ready;
  logic [4:0]    ll_reg;
  logic [31:0]   ll_data;
  logic          stall_pipe;
  logic [31:0]   pending;
  logic [CW-1:0] ll_count;
  logic          write;
  logic [4:0]    writereg;
  logic [31:0]   writedata;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]    byp_rs;
  logic [4:0]    byp_rt;
  logic          byp_rs_hit;
  logic          byp_rt_hit;
  logic [31:0]   byp_rs_data;
  logic [31:0]   byp_rt_data;

  modport master (
    output wb_valid, wb_reg, wb_mem_to_reg, wb_alu_result, wb_mem_data,
    output ll_valid, ll_reg, ll_data, byp_rs, byp_rt,
    input  ll_ready, stall_pipe, pending, ll_count, write, writereg, writedata,
    input  byp_rs_hit, byp_rt_hit, byp_rs_data, byp_rt_data
  );
  modport slave (
    input  wb_valid, wb_reg, wb_mem_to_reg, wb_alu_result, wb_mem_data,
    input  ll_valid, ll_reg, ll_data, byp_rs, byp_rt,
    output ll_ready, stall_pipe, pending, ll_count, write, writereg, writedata,
    output byp_rs_hit, byp_rt_hit, byp_rs_data, byp_rt_data
  );
`else
  modport master (
    output wb_valid, wb_reg, wb_mem_to_reg, wb_alu_result, wb_mem_data,
    output ll_valid, ll_reg, ll_data,
    input  ll_ready, stall_pipe, pending, ll_count, write, writereg, writedata
  );
  modport slave (
    input  wb_valid, wb_reg, wb_mem_to_reg, wb_alu_result, wb_mem_data,
    input  ll_valid, ll_reg, ll_data,
    output ll_ready, stall_pipe, pending, ll_count, write, writereg, writedata
  );
`endif
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges the in-order MEM/WB stream and a FIFO of long-latency results onto the register file write port.
// Optional macro RF_WB_BYPASS_EN adds combinational same-cycle bypass taps on the write port.
module rf_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int ZERO_DISCARD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rf_writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic          ZD_C    = (ZERO_DISCARD != 0);

  logic [4:0]       r_reg_mem  [DEPTH];
  logic [31:0]      r_data_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic             r_stall;
  logic             r_write;
  logic [4:0]       r_writereg;
  logic [31:0]      r_writedata;

  logic             w_empty;
  logic             w_ready;
  logic             w_wb_take;
  logic             w_enq;
  logic             w_deq;
  logic [31:0]      w_pending;

  // Arbitration: a zero-destination request is invisible, so the FIFO head may win instead.
  always_comb begin
    w_empty   = (r_count == {CW{1'b0}});
    w_ready   = (r_count < DEPTH_C);
    w_wb_take = bus.wb_valid & ~(ZD_C & (bus.wb_reg == 5'd0));
    w_enq     = bus.ll_valid & w_ready & ~(ZD_C & (bus.ll_reg == 5'd0));
    w_deq     = ~w_wb_take & ~w_empty;
  end

  // Pending-destination decode over live FIFO entries.
  always_comb begin
    w_pending = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pending = w_pending | (32'(r_vld[i]) << r_reg_mem[i]);
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_reg_mem[i]  <= 5'd0;
        r_data_mem[i] <= 32'd0;
      end
      r_vld    <= {DEPTH{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_enq) begin
        r_reg_mem[r_wr_ptr]  <= bus.ll_reg;
        r_data_mem[r_wr_ptr] <= bus.ll_data;
        r_vld[r_wr_ptr]      <= 1'b1;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_writereg  <= 5'd0;
      r_writedata <= 32'd0;
    end else if (w_wb_take) begin
      r_write     <= 1'b1;
      r_writereg  <= bus.wb_reg;
      r_writedata <= bus.wb_mem_to_reg ? bus.wb_mem_data : bus.wb_alu_result;
    end else if (w_deq) begin
      r_write     <= 1'b1;
      r_writereg  <= r_reg_mem[r_rd_ptr];
      r_writedata <= r_data_mem[r_rd_ptr];
    end else begin
      r_write     <= 1'b0;
    end
  end

  // Starvation counter; only a pipe win over a non-empty FIFO can leave both branches untaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= {SW{1'b0}};
      r_stall  <= 1'b0;
    end else if (w_deq || w_empty) begin
      r_starve <= {SW{1'b0}};
      r_stall  <= 1'b0;
    end else begin
      r_starve <= (r_starve == LIMIT_C) ? r_starve : r_starve + SW'(1);
      r_stall  <= r_stall | (r_starve >= LIMIT_C - SW'(1));
    end
  end

  assign bus.ll_ready   = w_ready;
  assign bus.ll_count   = r_count;
  assign bus.pending    = w_pending;
  assign bus.stall_pipe = r_stall;
  assign bus.write      = r_write;
  assign bus.writereg   = r_writereg;
  assign bus.writedata  = r_writedata;

`ifdef RF_WB_BYPASS_EN
  assign bus.byp_rs_hit  = r_write & (r_writereg == bus.byp_rs) & (r_writereg != 5'd0);
  assign bus.byp_rt_hit  = r_write & (r_writereg == bus.byp_rt) & (r_writereg != 5'd0);
  assign bus.byp_rs_data = r_writedata;
  assign bus.byp_rt_data = r_writedata;
`endif
endmodule
